pc_sequencer: RTL and testbench

- Parametrised program counter for the 4-bit computer; successor to the fixed-width free-running PC.
- An internal prescaler generates a one-cycle `step` strobe. On each step the PC increments, jumps (conditionally), calls or returns.
- Calls and returns use a small hardware return-address stack.
- Sits between the instruction decoder/ALU flags and program memory address.

---
 rtl/pc_seq_pkg.sv | 41 ++++
 rtl/pc_ret_stack.sv | 63 ++++++
 rtl/pc_sequencer.sv | 143 ++++++++++++++
 tb/tb_pc_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types, defaults and the next-PC helper for pc_sequencer.
// Contents:
//   pc_op_e   - the single operation resolved for each step cycle
//   pc_word_t - wide word the helper works in; callers truncate to AW bits
//   next_pc() - selects the next program address for a resolved operation
package pc_seq_pkg;

   localparam int unsigned PC_SEQ_AW_DEF    = 4;
   localparam int unsigned PC_SEQ_DIV_DEF   = 4;
   localparam int unsigned PC_SEQ_DEPTH_DEF = 4;
   localparam int unsigned PC_MAX_W         = 32;

   typedef enum logic [2:0] {
      OP_INC,
      OP_JMP,
      OP_CALL,
      OP_RET,
      OP_HOLD
   } pc_op_e;

   typedef logic [PC_MAX_W-1:0] pc_word_t;

   // Carries out of the caller's AW bits are dropped when the caller
   // truncates, which gives the modulo-2^AW wrap.
   function automatic pc_word_t next_pc(input pc_op_e   op,
                                        input pc_word_t pc,
                                        input pc_word_t addr,
                                        input pc_word_t top);
      pc_word_t r;
      r = pc;
      case (op)
         OP_INC:  r = pc + 1'b1;
         OP_JMP:  r = addr;
         OP_CALL: r = addr;
         OP_RET:  r = top;
         default: r = pc;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: synchronous LIFO holding return addresses.
// Ports:
//   clk, rst - clock, synchronous active-high reset (clears the level only)
//   push     - write din on top (ignored when full)
//   pop      - drop the top entry (ignored when empty; wins over push)
//   din      - return address to push
//   top      - current top entry ('0 when empty)
//   lvl      - number of occupied entries
//   full     - lvl == STACK_DEPTH
//   empty    - lvl == 0
module pc_ret_stack
   import pc_seq_pkg::*;
#(
   parameter int unsigned AW          = PC_SEQ_AW_DEF,
   parameter int unsigned STACK_DEPTH = PC_SEQ_DEPTH_DEF
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               push,
   input  logic                               pop,
   input  logic [AW-1:0]                      din,
   output logic [AW-1:0]                      top,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   lvl,
   output logic                               full,
   output logic                               empty
);

   localparam int unsigned LW = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [AW-1:0] mem [STACK_DEPTH];
   logic [LW-1:0] top_idx;
   logic          do_push;
   logic          do_pop;

   assign full    = (lvl == LW'(STACK_DEPTH));
   assign empty   = (lvl == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & ~pop & ~full;
   assign top_idx = lvl - 1'b1;

   always_comb begin
      top = '0;
      if (!empty)
         top = mem[top_idx[IW-1:0]];
   end

   // Entries need no reset: only entries below lvl are ever read.
   always_ff @(posedge clk) begin
      if (do_push)
         mem[lvl[IW-1:0]] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst)
         lvl <= '0;
      else if (do_push)
         lvl <= lvl + 1'b1;
      else if (do_pop)
         lvl <= lvl - 1'b1;
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: parametrised program counter with prescaled step strobe,
// conditional jump, call/return through a hardware return stack.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   halt      - freeze prescaler and PC, suppress step
//   jmp_req   - jump request, taken only with jmp_cond=1
//   jmp_cond  - jump condition flag
//   jmp_addr  - jump/call target
//   call_req  - push pc+1 and load jmp_addr
//   ret_req   - pop return address into pc
//   ss_mode, ss_pulse - single-step controls (only with PC_SEQ_SINGLE_STEP_EN)
//   pc        - current program address
//   step      - one-cycle strobe; requests are sampled in this cycle
//   stack_lvl - occupied return-stack entries
//   stack_err - sticky overflow/underflow flag
// Optional feature macro: PC_SEQ_SINGLE_STEP_EN adds ss_mode/ss_pulse.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned AW          = PC_SEQ_AW_DEF,
   parameter int unsigned DIV         = PC_SEQ_DIV_DEF,
   parameter int unsigned STACK_DEPTH = PC_SEQ_DEPTH_DEF
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               halt,
   input  logic                               jmp_req,
   input  logic                               jmp_cond,
   input  logic [AW-1:0]                      jmp_addr,
   input  logic                               call_req,
   input  logic                               ret_req,
`ifdef PC_SEQ_SINGLE_STEP_EN
   input  logic                               ss_mode,
   input  logic                               ss_pulse,
`endif
   output logic [AW-1:0]                      pc,
   output logic                               step,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_lvl,
   output logic                               stack_err
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0] presc;
   logic          presc_wrap;
   pc_op_e        op;
   logic          err_set;
   logic [AW-1:0] pc_nxt;
   logic [AW-1:0] ret_addr;
   logic [AW-1:0] stk_top;
   logic          stk_full;
   logic          stk_empty;

   assign presc_wrap = (presc == PW'(DIV - 1));
   assign ret_addr   = pc + 1'b1;

   // Prescaler and step strobe
`ifdef PC_SEQ_SINGLE_STEP_EN
   always_comb begin
      step = presc_wrap & ~halt;
      if (ss_mode)
         step = ss_pulse & ~halt;
   end

   // Holding the count at 0 while in single-step mode also makes every
   // mode switch restart the prescaler from 0.
   always_ff @(posedge clk) begin
      if (rst || ss_mode)
         presc <= '0;
      else if (!halt)
         presc <= presc_wrap ? '0 : presc + 1'b1;
   end
`else
   always_comb begin
      step = presc_wrap & ~halt;
   end

   always_ff @(posedge clk) begin
      if (rst)
         presc <= '0;
      else if (!halt)
         presc <= presc_wrap ? '0 : presc + 1'b1;
   end
`endif

   // Priority resolve: ret > call > jmp > increment. Rejected stack
   // operations fall back to a plain increment and raise the error flag.
   always_comb begin
      op      = OP_HOLD;
      err_set = 1'b0;
      if (step) begin
         if (ret_req) begin
            if (!stk_empty) begin
               op = OP_RET;
            end else begin
               op      = OP_INC;
               err_set = 1'b1;
            end
         end else if (call_req) begin
            if (!stk_full) begin
               op = OP_CALL;
            end else begin
               op      = OP_INC;
               err_set = 1'b1;
            end
         end else if (jmp_req && jmp_cond) begin
            op = OP_JMP;
         end else begin
            op = OP_INC;
         end
      end
   end

   assign pc_nxt = AW'(next_pc(op, pc_word_t'(pc), pc_word_t'(jmp_addr),
                               pc_word_t'(stk_top)));

   pc_ret_stack #(
      .AW          (AW),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (op == OP_CALL),
      .pop   (op == OP_RET),
      .din   (ret_addr),
      .top   (stk_top),
      .lvl   (stack_lvl),
      .full  (stk_full),
      .empty (stk_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc        <= '0;
         stack_err <= 1'b0;
      end else begin
         pc <= pc_nxt;
         if (err_set)
            stack_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plus random stimulus for pc_sequencer, checked
// every cycle against a queue-based behavioural model of the sequencer.
module tb_pc_sequencer;

   localparam int unsigned AW    = 4;
   localparam int unsigned DIV   = 4;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned LW    = $clog2(DEPTH + 1);
   localparam int          MOD   = 1 << AW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          halt = 1'b0;
   logic          jmp_req = 1'b0;
   logic          jmp_cond = 1'b0;
   logic [AW-1:0] jmp_addr = '0;
   logic          call_req = 1'b0;
   logic          ret_req = 1'b0;
`ifdef PC_SEQ_SINGLE_STEP_EN
   logic          ss_mode = 1'b0;
   logic          ss_pulse = 1'b0;
`endif
   logic [AW-1:0] pc;
   logic          step;
   logic [LW-1:0] stack_lvl;
   logic          stack_err;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_pc    = 0;
   int m_ticks = 0;
   bit m_err   = 1'b0;
   int m_stk[$];
   bit last_exp_step = 1'b0;
   logic last_dut_step = 1'b0;

   pc_sequencer #(
      .AW          (AW),
      .DIV         (DIV),
      .STACK_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .halt      (halt),
      .jmp_req   (jmp_req),
      .jmp_cond  (jmp_cond),
      .jmp_addr  (jmp_addr),
      .call_req  (call_req),
      .ret_req   (ret_req),
`ifdef PC_SEQ_SINGLE_STEP_EN
      .ss_mode   (ss_mode),
      .ss_pulse  (ss_pulse),
`endif
      .pc        (pc),
      .step      (step),
      .stack_lvl (stack_lvl),
      .stack_err (stack_err)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_step();
      bit ssm;
      bit ssp;
      ssm = 1'b0;
      ssp = 1'b0;
`ifdef PC_SEQ_SINGLE_STEP_EN
      ssm = ss_mode;
      ssp = ss_pulse;
`endif
      if (ssm)
         return ssp && !halt;
      return !halt && (m_ticks == DIV - 1);
   endfunction

   // Check DUT against model mid-cycle, then advance the model over the edge.
   task automatic cycle();
      bit es;
      bit ssm;
      @(negedge clk);
      es = model_step();
      if (!rst) chk("step", 32'(step), 32'(es));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("stack_lvl", 32'(stack_lvl), 32'(m_stk.size()));
      chk("stack_err", 32'(stack_err), 32'(m_err));
      last_exp_step = es;
      last_dut_step = step;
      @(posedge clk);
      ssm = 1'b0;
`ifdef PC_SEQ_SINGLE_STEP_EN
      ssm = ss_mode;
`endif
      if (rst) begin
         m_pc = 0; m_ticks = 0; m_err = 1'b0; m_stk.delete();
      end else begin
         if (es) begin
            if (ret_req) begin
               if (m_stk.size() > 0) m_pc = m_stk.pop_back();
               else begin m_pc = (m_pc + 1) % MOD; m_err = 1'b1; end
            end else if (call_req) begin
               if (m_stk.size() < DEPTH) begin
                  m_stk.push_back((m_pc + 1) % MOD);
                  m_pc = int'(jmp_addr);
               end else begin
                  m_pc = (m_pc + 1) % MOD; m_err = 1'b1;
               end
            end else if (jmp_req && jmp_cond) m_pc = int'(jmp_addr);
            else m_pc = (m_pc + 1) % MOD;
         end
         if (ssm) m_ticks = 0;
         else if (!halt) m_ticks = (m_ticks + 1) % DIV;
      end
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   // Hold current requests until a step cycle consumes them (bounded).
   task automatic run_to_step();
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 3 * DIV + 4; i++) begin
         cycle();
         if (last_exp_step) begin hit = 1'b1; break; end
      end
      chk("step_timeout", 32'(hit), 32'd1);
   endtask

   task automatic clear_req();
      jmp_req = 1'b0; jmp_cond = 1'b0; call_req = 1'b0; ret_req = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; clear_req(); halt = 1'b0;
      run(2);
      rst = 1'b0;
   endtask

   initial begin
      #1;
      // Reset and free-running increment with wrap
      do_reset();
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_lvl", 32'(stack_lvl), 32'd0);
      run(4);
      chk("inc_pc1", 32'(pc), 32'd1);
      run(60);
      chk("wrap_pc0", 32'(pc), 32'd0);

      // Conditional jump at pc=5
      run(20);
      chk("at_pc5", 32'(pc), 32'd5);
      jmp_req = 1'b1; jmp_cond = 1'b0; jmp_addr = 4'hC;
      run_to_step(); clear_req();
      cycle();
      chk("jmp_nt", 32'(pc), 32'd6);
      jmp_req = 1'b1; jmp_cond = 1'b1; jmp_addr = 4'hC;
      run_to_step(); clear_req();
      cycle();
      chk("jmp_t", 32'(pc), 32'hC);
      jmp_req = 1'b1; jmp_cond = 1'b1; jmp_addr = 4'h2;
      cycle(); clear_req();
      run_to_step();
      cycle();
      chk("jmp_offstep", 32'(pc), 32'hD);

      // Call / return at pc=3
      do_reset();
      run(12);
      chk("at_pc3", 32'(pc), 32'd3);
      call_req = 1'b1; jmp_addr = 4'hA;
      run_to_step(); clear_req();
      cycle();
      chk("call_pc", 32'(pc), 32'hA);
      chk("call_lvl", 32'(stack_lvl), 32'd1);
      run_to_step();
      ret_req = 1'b1;
      run_to_step(); clear_req();
      cycle();
      chk("ret_pc", 32'(pc), 32'd4);
      chk("ret_lvl", 32'(stack_lvl), 32'd0);

      // Overflow: five nested calls
      do_reset();
      for (int i = 0; i < 5; i++) begin
         call_req = 1'b1;
         jmp_addr = (i < 4) ? AW'(8 + i) : '0;
         run_to_step();
      end
      clear_req();
      cycle();
      chk("ovf_pc", 32'(pc), 32'd12);
      chk("ovf_lvl", 32'(stack_lvl), 32'd4);
      chk("ovf_err", 32'(stack_err), 32'd1);

      // Underflow after reset
      do_reset();
      chk("err_clr", 32'(stack_err), 32'd0);
      ret_req = 1'b1;
      run_to_step(); clear_req();
      cycle();
      chk("udf_pc", 32'(pc), 32'd1);
      chk("udf_err", 32'(stack_err), 32'd1);

      // Priority: ret beats call and jmp
      do_reset();
      call_req = 1'b1; jmp_addr = 4'h6;
      run_to_step(); clear_req();
      ret_req = 1'b1; call_req = 1'b1; jmp_req = 1'b1; jmp_cond = 1'b1; jmp_addr = 4'h9;
      run_to_step(); clear_req();
      cycle();
      chk("prio_pc", 32'(pc), 32'd1);
      chk("prio_lvl", 32'(stack_lvl), 32'd0);
      chk("prio_err", 32'(stack_err), 32'd0);

      // Halt mid-count (prescaler at 2 after the cycle above and one more)
      cycle();
      halt = 1'b1;
      run(10);
      chk("halt_pc", 32'(pc), 32'd1);
      halt = 1'b0;
      cycle();
      chk("rel_nostep", 32'(last_dut_step), 32'd0);
      cycle();
      chk("rel_step", 32'(last_dut_step), 32'd1);
      cycle();
      chk("rel_pc", 32'(pc), 32'd2);

`ifdef PC_SEQ_SINGLE_STEP_EN
      begin
         int base;
         base = m_pc;
         ss_mode = 1'b1; ss_pulse = 1'b0;
         run(3);
         for (int k = 0; k < 3; k++) begin
            ss_pulse = 1'b1;
            cycle();
            chk("ss_step", 32'(last_dut_step), 32'd1);
            ss_pulse = 1'b0;
            run(6);
         end
         chk("ss_pc", 32'(pc), 32'((base + 3) % MOD));
         ss_mode = 1'b0;
         run(5);
      end
`endif

      // Random traffic against the model
      do_reset();
      for (int i = 0; i < 800; i++) begin
         rst      = ($urandom_range(0, 63) == 0);
         halt     = ($urandom_range(0, 7) == 0);
         ret_req  = ($urandom_range(0, 5) == 0);
         call_req = ($urandom_range(0, 4) == 0);
         jmp_req  = ($urandom_range(0, 2) == 0);
         jmp_cond = 1'($urandom);
         jmp_addr = AW'($urandom);
         cycle();
      end
      rst = 1'b0; halt = 1'b0; clear_req();
      run(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
